// File: rtl/cmp_vector_gen.sv
// cmp_vector_gen: stimulus source for the equality comparator datapath.
// Sweeps the whole 2*WIDTH-bit operand-pair space once per start, handing
// each pair and its expected equality result out over valid/ready.
// Optional build macro CMP_VECTOR_GEN_LFSR_MODE_EN: pairs come from a 6-bit
// maximal-length LFSR (63 nonzero pairs) instead of a binary counter (64 pairs).
module cmp_vector_gen #(
  parameter int unsigned             WIDTH     = 3,
  parameter logic [2*WIDTH-1:0]      LFSR_SEED = 6'h01
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 vec_ready,
  output logic                 vec_valid,
  output logic [WIDTH-1:0]     vec_a,
  output logic [WIDTH-1:0]     vec_b,
  output logic                 exp_equal,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     vec_count
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = 2 * WIDTH + 1;

`ifdef CMP_VECTOR_GEN_LFSR_MODE_EN
  localparam logic [PW-1:0] FIRST_P = LFSR_SEED;

  // The feedback taps are fixed for the 6-bit polynomial x^6+x^5+1.
  if (WIDTH != 3) begin : g_width_check
    $error("cmp_vector_gen: LFSR mode supports only WIDTH=3");
  end
`else
  localparam logic [PW-1:0] FIRST_P = '0;
`endif

  // An all-zero seed would lock the LFSR; reject it at elaboration.
  if (LFSR_SEED == '0) begin : g_seed_check
    $error("cmp_vector_gen: LFSR_SEED must be nonzero");
  end

  localparam logic FIRST_EQ = (FIRST_P[PW-1:WIDTH] == FIRST_P[WIDTH-1:0]);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   p;
  logic [PW-1:0]   p_next;
  logic            last_c;
  logic            next_eq;

  // Successor pair, end-of-sweep detection and expected result for the successor.
  always_comb begin
    p_next  = '0;
    last_c  = 1'b0;
`ifdef CMP_VECTOR_GEN_LFSR_MODE_EN
    p_next  = {p[PW-2:0], p[PW-1] ^ p[PW-2]};
    last_c  = (p_next == LFSR_SEED);
`else
    p_next  = p + PW'(1);
    last_c  = (p == '1);
`endif
    next_eq = (p_next[PW-1:WIDTH] == p_next[WIDTH-1:0]);
  end

  // Sweep controller: pair register, handshake bookkeeping and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      p         <= '0;
      exp_equal <= 1'b0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vec_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= SEND;
            p         <= FIRST_P;
            exp_equal <= FIRST_EQ;
            vec_valid <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            vec_count <= '0;
          end
        end
        SEND: begin
          if (vec_ready) begin
            vec_count <= vec_count + CW'(1);
            if (last_c) begin
              // Last pair stays on the outputs; valid drops with this transfer.
              state     <= DONE;
              vec_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              p         <= p_next;
              exp_equal <= next_eq;
            end
          end
        end
        default: begin
          state     <= IDLE;
          vec_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  assign vec_a = p[PW-1:WIDTH];
  assign vec_b = p[WIDTH-1:0];

endmodule

// File: tb/tb_cmp_vector_gen.sv
// Testbench for cmp_vector_gen: directed sweeps with randomized back-pressure,
// checked against a pair-sequence model built from the sweep rules.
module tb_cmp_vector_gen;

  localparam int unsigned W  = 3;
  localparam int unsigned PW = 2 * W;
`ifdef CMP_VECTOR_GEN_LFSR_MODE_EN
  localparam int N   = 63;
  localparam int NEQ = 7;
`else
  localparam int N   = 64;
  localparam int NEQ = 8;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          vec_ready;
  logic          vec_valid;
  logic [W-1:0]  vec_a;
  logic [W-1:0]  vec_b;
  logic          exp_equal;
  logic          busy;
  logic          done;
  logic [2*W:0]  vec_count;

  int n_cmp = 0;
  int n_bad = 0;
  int seq [64];

  cmp_vector_gen #(.WIDTH(W), .LFSR_SEED(6'h01)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vec_ready (vec_ready),
    .vec_valid (vec_valid),
    .vec_a     (vec_a),
    .vec_b     (vec_b),
    .exp_equal (exp_equal),
    .busy      (busy),
    .done      (done),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({vec_valid, busy, done, vec_a, vec_b, exp_equal, vec_count});
  endfunction

  // mode 0: ready always high; 1: random ready; 2: 3-cycle stall at pair index 21.
  task automatic run_sweep(input int mode, input int mid_start);
    int k = 0;
    int cycles = 0;
    int stalls = 0;
    int neq = 0;
    int distinct = 0;
    int zero_seen = 0;
    int idx;
    bit r;
    bit seen [64];
    logic [5:0] pv;
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    start = 1'b1;
    vec_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("count_cleared", 32'(vec_count), 32'd0);
    while (!done && cycles < N + 300) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: r = !(k == 21 && stalls < 3);
      endcase
      idx = (k < N) ? k : N - 1;
      pv = 6'(seq[idx]);
      chk("pair_state", 32'({vec_valid, busy, done, vec_a, vec_b}),
          32'({(k < N), (k < N), 1'b0, pv}));
      chk("exp_equal", 32'(exp_equal), 32'(pv[5:3] == pv[2:0]));
      chk("count_run", 32'(vec_count), 32'(k));
      chk("busy_done_excl", 32'(busy && done), 32'd0);
      vec_ready = r;
      start = (cycles == mid_start);
      if (r && vec_valid) begin
        if (exp_equal) neq++;
        if ({vec_a, vec_b} == 6'd0) zero_seen++;
        if (!seen[{vec_a, vec_b}]) distinct++;
        seen[{vec_a, vec_b}] = 1'b1;
        k++;
      end else begin
        stalls++;
      end
      tick();
      cycles++;
    end
    start = 1'b0;
    vec_ready = 1'b1;
    chk("done_level", 32'(done), 32'd1);
    chk("transfers", 32'(k), 32'(N));
    chk("start_to_done", 32'(cycles), 32'(N + stalls));
    chk("final_count", 32'(vec_count), 32'(N));
    chk("valid_busy_off", 32'({vec_valid, busy}), 32'd0);
    chk("eq_hits", 32'(neq), 32'(NEQ));
    chk("distinct", 32'(distinct), 32'(N));
`ifdef CMP_VECTOR_GEN_LFSR_MODE_EN
    chk("no_zero_pair", 32'(zero_seen), 32'd0);
`else
    chk("zero_pair_once", 32'(zero_seen), 32'd1);
`endif
  endtask

  initial begin
    int p;
    int guard;
    // Expected pair order, derived from the sweep rules.
`ifdef CMP_VECTOR_GEN_LFSR_MODE_EN
    p = 1;
    for (int i = 0; i < 63; i++) begin
      seq[i] = p;
      p = ((p * 2) % 64) + (((p / 32) + (p / 16)) % 2);
    end
    seq[63] = 0;
`else
    for (int i = 0; i < 64; i++) seq[i] = i;
`endif

    rst_n = 1'b0;
    start = 1'b0;
    vec_ready = 1'b0;
    #12;
    chk("reset_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_outputs", all_outs(), 32'd0);

    run_sweep(0, -1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_hold", 32'({vec_valid, busy, done, vec_count}), 32'({3'b001, 7'(N)}));
    end

    run_sweep(2, 10);
    run_sweep(1, -1);

    // Asynchronous reset in the middle of a sweep.
    start = 1'b1;
    vec_ready = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (vec_count != 7'd32 && guard < 200) begin
      tick();
      guard++;
    end
    chk("reached_mid", 32'({vec_a, vec_b}), 32'(seq[32]));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", all_outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", all_outs(), 32'd0);

    run_sweep(1, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
